// File: rtl/video_win_pkg.sv
// Shared types and home-layout helpers for the video window mover.
package video_win_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StCalc,
    StAddr,
    StDone
  } vwm_state_e;

  // Bits needed to hold a coordinate in 0..extent (XW / YW).
  function automatic int unsigned coord_w(input int unsigned extent);
    return $clog2(extent + 1);
  endfunction

  function automatic int unsigned home_x(input int unsigned k, input int unsigned cols,
                                         input int unsigned win_w);
    return (k % cols) * win_w;
  endfunction

  function automatic int unsigned home_y(input int unsigned k, input int unsigned cols,
                                         input int unsigned win_h);
    return (k / cols) * win_h;
  endfunction

  // 1 means the positive direction.
  function automatic logic init_dx(input int unsigned k);
    return (k % 2) == 0;
  endfunction

  function automatic logic init_dy(input int unsigned k, input int unsigned cols);
    return k < cols;
  endfunction

endpackage

// File: rtl/vwm_sync_edge.sv
// Two-flop synchroniser followed by a rising-edge detector.
module vwm_sync_edge (
  input  logic I_sys_clk,
  input  logic I_rst_n,
  input  logic I_sig,
  output logic O_rise
);

  logic [2:0] sh_q, sh_d;

  always_comb sh_d = {sh_q[1:0], I_sig};

  always_ff @(posedge I_sys_clk or negedge I_rst_n) begin
    if (!I_rst_n) sh_q <= '0;
    else          sh_q <= sh_d;
  end

  // sh_q[1] is the synced level, sh_q[2] its previous value.
  assign O_rise = sh_q[1] & ~sh_q[2];

endmodule

// File: rtl/video_window_mover.sv
// Bounces CH_NUM video windows around the frame once per vsync and derives their DDR
// start addresses; all outputs change together when an update completes.
module video_window_mover
  import video_win_pkg::*;
#(
  parameter int unsigned CH_NUM         = 4,
  parameter int unsigned GRID_COLS      = 2,
  parameter int unsigned H_ACT          = 1280,
  parameter int unsigned V_ACT          = 720,
  parameter int unsigned WIN_W          = 640,
  parameter int unsigned WIN_H          = 360,
  parameter int unsigned STEP           = 2,
  parameter int unsigned PIX_BYTES      = 4,
  parameter int unsigned BASE_ADDR      = 0,
  parameter int unsigned AXI_ADDR_WIDTH = 29,
  localparam int unsigned XW            = coord_w(H_ACT),
  localparam int unsigned YW            = coord_w(V_ACT)
) (
  input  logic                             I_sys_clk,
  input  logic                             I_rst_n,
  input  logic                             I_vs,
  input  logic                             I_move_en,
  output logic [CH_NUM*XW-1:0]             O_win_x,
  output logic [CH_NUM*YW-1:0]             O_win_y,
  output logic [CH_NUM*AXI_ADDR_WIDTH-1:0] O_win_addr,
  output logic                             O_upd_done,
  output logic                             O_busy
);

  localparam int unsigned AW   = AXI_ADDR_WIDTH;
  localparam int unsigned KW   = (CH_NUM > 1) ? $clog2(CH_NUM) : 1;
  localparam int unsigned XMAX = H_ACT - WIN_W;
  localparam int unsigned YMAX = V_ACT - WIN_H;
  localparam logic [KW-1:0] KLast = KW'(CH_NUM - 1);

  if (CH_NUM < 1 || CH_NUM > 8) begin : g_bad_ch
    $error("CH_NUM must be 1..8");
  end
  if (WIN_W > H_ACT || WIN_H > V_ACT) begin : g_bad_win
    $error("window larger than frame");
  end
  if (STEP == 0) begin : g_bad_step
    $error("STEP must be nonzero");
  end
  if (GRID_COLS == 0) begin : g_bad_cols
    $error("GRID_COLS must be nonzero");
  end else begin : g_home_chk
    for (genvar g = 0; g < CH_NUM; g++) begin : g_ch
      if (home_x(g, GRID_COLS, WIN_W) + WIN_W > H_ACT ||
          home_y(g, GRID_COLS, WIN_H) + WIN_H > V_ACT) begin : g_bad_home
        $error("home position outside frame");
      end
    end
  end

  // Address arithmetic done at AW bits wraps exactly like truncating the full result.
  function automatic logic [AW-1:0] pix_addr(input logic [XW-1:0] x, input logic [YW-1:0] y);
    return AW'(BASE_ADDR) + (AW'(y) * AW'(H_ACT) + AW'(x)) * AW'(PIX_BYTES);
  endfunction

  function automatic logic [XW-1:0] hx(input int unsigned k);
    return XW'(home_x(k, GRID_COLS, WIN_W));
  endfunction

  function automatic logic [YW-1:0] hy(input int unsigned k);
    return YW'(home_y(k, GRID_COLS, WIN_H));
  endfunction

  logic vs_rise;

  vwm_sync_edge u_vs_sync (
    .I_sys_clk (I_sys_clk),
    .I_rst_n   (I_rst_n),
    .I_sig     (I_vs),
    .O_rise    (vs_rise)
  );

  logic [1:0] men_q, men_d;

  vwm_state_e      state_q, state_d;
  logic [KW-1:0]   k_q, k_d;
  logic            move_q, move_d;
  logic [XW-1:0]   x_q [CH_NUM];
  logic [XW-1:0]   x_d [CH_NUM];
  logic [YW-1:0]   y_q [CH_NUM];
  logic [YW-1:0]   y_d [CH_NUM];
  logic [CH_NUM-1:0] dx_q, dx_d, dy_q, dy_d;
  logic [AW-1:0]   addr_q [CH_NUM];
  logic [AW-1:0]   addr_d [CH_NUM];
  logic [XW-1:0]   out_x_q [CH_NUM];
  logic [XW-1:0]   out_x_d [CH_NUM];
  logic [YW-1:0]   out_y_q [CH_NUM];
  logic [YW-1:0]   out_y_d [CH_NUM];
  logic [AW-1:0]   out_addr_q [CH_NUM];
  logic [AW-1:0]   out_addr_d [CH_NUM];

  always_comb begin
    men_d      = {men_q[0], I_move_en};
    state_d    = state_q;
    k_d        = k_q;
    move_d     = move_q;
    x_d        = x_q;
    y_d        = y_q;
    dx_d       = dx_q;
    dy_d       = dy_q;
    addr_d     = addr_q;
    out_x_d    = out_x_q;
    out_y_d    = out_y_q;
    out_addr_d = out_addr_q;

    unique case (state_q)
      StIdle: begin
        if (vs_rise) begin
          state_d = StCalc;
          k_d     = '0;
          move_d  = men_q[1];
        end
      end
      StCalc: begin
        if (!move_q) begin
          x_d[k_q]  = hx(32'(k_q));
          y_d[k_q]  = hy(32'(k_q));
          dx_d[k_q] = init_dx(32'(k_q));
          dy_d[k_q] = init_dy(32'(k_q), GRID_COLS);
        end else begin
          if (dx_q[k_q]) begin
            if (32'(x_q[k_q]) + STEP >= XMAX) begin
              x_d[k_q]  = XW'(XMAX);
              dx_d[k_q] = 1'b0;
            end else begin
              x_d[k_q] = x_q[k_q] + XW'(STEP);
            end
          end else if (32'(x_q[k_q]) <= STEP) begin
            x_d[k_q]  = '0;
            dx_d[k_q] = 1'b1;
          end else begin
            x_d[k_q] = x_q[k_q] - XW'(STEP);
          end

          if (dy_q[k_q]) begin
            if (32'(y_q[k_q]) + STEP >= YMAX) begin
              y_d[k_q]  = YW'(YMAX);
              dy_d[k_q] = 1'b0;
            end else begin
              y_d[k_q] = y_q[k_q] + YW'(STEP);
            end
          end else if (32'(y_q[k_q]) <= STEP) begin
            y_d[k_q]  = '0;
            dy_d[k_q] = 1'b1;
          end else begin
            y_d[k_q] = y_q[k_q] - YW'(STEP);
          end
        end
        if (k_q == KLast) begin
          k_d     = '0;
          state_d = StAddr;
        end else begin
          k_d = k_q + 1'b1;
        end
      end
      StAddr: begin
        addr_d[k_q] = pix_addr(x_q[k_q], y_q[k_q]);
        if (k_q == KLast) begin
          k_d     = '0;
          state_d = StDone;
          // Shadow-to-output copy lands on the edge that opens DONE, so the
          // done pulse coincides with the new values.
          out_x_d    = x_q;
          out_y_d    = y_q;
          out_addr_d = addr_d;
        end else begin
          k_d = k_q + 1'b1;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge I_sys_clk or negedge I_rst_n) begin
    if (!I_rst_n) begin
      men_q   <= '0;
      state_q <= StIdle;
      k_q     <= '0;
      move_q  <= 1'b0;
      for (int unsigned k = 0; k < CH_NUM; k++) begin
        x_q[k]        <= hx(k);
        y_q[k]        <= hy(k);
        dx_q[k]       <= init_dx(k);
        dy_q[k]       <= init_dy(k, GRID_COLS);
        addr_q[k]     <= pix_addr(hx(k), hy(k));
        out_x_q[k]    <= hx(k);
        out_y_q[k]    <= hy(k);
        out_addr_q[k] <= pix_addr(hx(k), hy(k));
      end
    end else begin
      men_q      <= men_d;
      state_q    <= state_d;
      k_q        <= k_d;
      move_q     <= move_d;
      x_q        <= x_d;
      y_q        <= y_d;
      dx_q       <= dx_d;
      dy_q       <= dy_d;
      addr_q     <= addr_d;
      out_x_q    <= out_x_d;
      out_y_q    <= out_y_d;
      out_addr_q <= out_addr_d;
    end
  end

  for (genvar g = 0; g < CH_NUM; g++) begin : g_pack
    assign O_win_x[g*XW +: XW]       = out_x_q[g];
    assign O_win_y[g*YW +: YW]       = out_y_q[g];
    assign O_win_addr[g*AW +: AW]    = out_addr_q[g];
  end

  assign O_upd_done = (state_q == StDone);
  assign O_busy     = (state_q != StIdle);

endmodule

// File: tb/tb_video_window_mover.sv
// Bench for video_window_mover: a STEP=2 and a STEP=3 instance share stimulus and are
// compared against a per-frame arithmetic model of the bouncing windows.
module tb_video_window_mover;

  localparam int CH = 4;
  localparam int XW = 11;
  localparam int YW = 10;
  localparam int AW = 29;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic vs = 1'b0;
  logic men = 1'b0;

  logic [CH*XW-1:0] wx0, wx1;
  logic [CH*YW-1:0] wy0, wy1;
  logic [CH*AW-1:0] wa0, wa1;
  logic done0, done1, busy0, busy1;

  int n_checks = 0;
  int n_errors = 0;

  int mx[2][CH];
  int my[2][CH];
  bit mdx[2][CH];
  bit mdy[2][CH];

  always #5 clk = ~clk;

  video_window_mover dut (
    .I_sys_clk  (clk),
    .I_rst_n    (rst_n),
    .I_vs       (vs),
    .I_move_en  (men),
    .O_win_x    (wx0),
    .O_win_y    (wy0),
    .O_win_addr (wa0),
    .O_upd_done (done0),
    .O_busy     (busy0)
  );

  video_window_mover #(.STEP(3)) dut3 (
    .I_sys_clk  (clk),
    .I_rst_n    (rst_n),
    .I_vs       (vs),
    .I_move_en  (men),
    .O_win_x    (wx1),
    .O_win_y    (wy1),
    .O_win_addr (wa1),
    .O_upd_done (done1),
    .O_busy     (busy1)
  );

  task automatic check_val(input string tag, input longint obs, input longint exp);
    n_checks++;
    if (obs != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic void model_home(input int i, input int k);
    mx[i][k]  = (k % 2) * 640;
    my[i][k]  = (k / 2) * 360;
    mdx[i][k] = (k % 2) == 0;
    mdy[i][k] = k < 2;
  endfunction

  function automatic void model_reset();
    for (int i = 0; i < 2; i++)
      for (int k = 0; k < CH; k++) model_home(i, k);
  endfunction

  function automatic void model_tick(input bit move);
    int s;
    for (int i = 0; i < 2; i++) begin
      s = (i == 0) ? 2 : 3;
      for (int k = 0; k < CH; k++) begin
        if (!move) begin
          model_home(i, k);
        end else begin
          if (mdx[i][k]) begin
            mx[i][k] = (mx[i][k] + s > 640) ? 640 : mx[i][k] + s;
            if (mx[i][k] == 640) mdx[i][k] = 0;
          end else begin
            mx[i][k] = (mx[i][k] - s < 0) ? 0 : mx[i][k] - s;
            if (mx[i][k] == 0) mdx[i][k] = 1;
          end
          if (mdy[i][k]) begin
            my[i][k] = (my[i][k] + s > 360) ? 360 : my[i][k] + s;
            if (my[i][k] == 360) mdy[i][k] = 0;
          end else begin
            my[i][k] = (my[i][k] - s < 0) ? 0 : my[i][k] - s;
            if (my[i][k] == 0) mdy[i][k] = 1;
          end
        end
      end
    end
  endfunction

  task automatic check_outputs(input string where);
    logic [CH*XW-1:0] px;
    logic [CH*YW-1:0] py;
    logic [CH*AW-1:0] pa;
    for (int i = 0; i < 2; i++) begin
      px = (i == 0) ? wx0 : wx1;
      py = (i == 0) ? wy0 : wy1;
      pa = (i == 0) ? wa0 : wa1;
      for (int k = 0; k < CH; k++) begin
        check_val($sformatf("%s_u%0d_x%0d", where, i, k), px[k*XW +: XW], mx[i][k]);
        check_val($sformatf("%s_u%0d_y%0d", where, i, k), py[k*YW +: YW], my[i][k]);
        check_val($sformatf("%s_u%0d_addr%0d", where, i, k), pa[k*AW +: AW],
                  longint'((my[i][k] * 1280 + mx[i][k]) * 4));
      end
    end
  endtask

  // One vsync pulse; done must appear exactly 11 clocks after vs rises
  // (2 synchroniser clocks + 9 update clocks).
  task automatic run_frame(input bit move, input string where);
    int lat = -1;
    int nd0 = 0;
    int nd1 = 0;
    @(negedge clk);
    men = move;
    repeat (3) @(negedge clk);
    vs = 1'b1;
    for (int c = 1; c <= 30; c++) begin
      @(negedge clk);
      if (c == 2) vs = 1'b0;
      if (c == 3) check_val({where, "_busy"}, busy0, 1);
      if (done0) begin
        nd0++;
        if (lat < 0) lat = c;
      end
      if (done1) nd1++;
    end
    model_tick(move);
    check_val({where, "_done_lat"}, lat, 11);
    check_val({where, "_done_cnt"}, nd0, 1);
    check_val({where, "_done_cnt3"}, nd1, 1);
    check_outputs(where);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    vs = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    model_reset();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    int nd;
    repeat (3) @(negedge clk);
    model_reset();
    check_outputs("reset");
    check_val("reset_busy", busy0, 0);
    check_val("reset_done", done0, 0);
    check_val("reset_addr3", wa0[3*AW +: AW], 1845760);
    rst_n = 1'b1;

    run_frame(1'b0, "hold");

    run_frame(1'b1, "move1");
    check_val("move1_x0", wx0[0 +: XW], 2);
    check_val("move1_x1", wx0[XW +: XW], 638);
    check_val("move1_y2", wy0[2*YW +: YW], 358);
    check_val("move1_addr0", wa0[0 +: AW], 10248);

    // Second vs rise 3 clocks after the first lands while busy.
    @(negedge clk);
    men = 1'b1;
    repeat (3) @(negedge clk);
    vs = 1'b1;
    @(negedge clk) vs = 1'b0;
    @(negedge clk);
    @(negedge clk) vs = 1'b1;
    @(negedge clk);
    @(negedge clk) vs = 1'b0;
    nd = (done0 ? 1 : 0);
    for (int c = 0; c < 35; c++) begin
      @(negedge clk);
      if (done0) nd++;
    end
    model_tick(1'b1);
    check_val("dbl_done_cnt", nd, 1);
    check_outputs("dbl");

    // Reset while in CALC.
    @(negedge clk);
    repeat (3) @(negedge clk);
    vs = 1'b1;
    @(negedge clk);
    @(negedge clk) vs = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check_val("midrst_busy_before", busy0, 1);
    rst_n = 1'b0;
    #1;
    model_reset();
    check_outputs("midrst");
    check_val("midrst_busy", busy0, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    nd = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (done0 || done1) nd++;
    end
    check_val("midrst_no_done", nd, 0);
    run_frame(1'b1, "after_rst");

    // Long run to reach the STEP=3 right-edge clamp on channel 0.
    do_reset();
    for (int t = 1; t <= 215; t++) begin
      run_frame(1'b1, $sformatf("run%0d", t));
      if (t == 213) check_val("step3_x_213", wx1[0 +: XW], 639);
      if (t == 214) check_val("step3_x_214", wx1[0 +: XW], 640);
      if (t == 215) check_val("step3_x_215", wx1[0 +: XW], 637);
    end

    for (int t = 0; t < 20; t++) begin
      repeat ($urandom_range(0, 5)) @(negedge clk);
      run_frame(1'($urandom_range(0, 1)), $sformatf("rnd%0d", t));
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
